ex_hazard_alu: RTL and testbench
================================

EX_HAZARD_ALU -- requirements
Module: ex_hazard_alu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are named clock and reset as in the codebase, and reset is sampled only on the rising edge of clock.
REQ-002 Parameter DATA_W, default 32, SHALL set the ALU operand and result width.
REQ-003 Parameter RID_W, default 4, SHALL set the register-id width.
REQ-004 Parameter OP_W, default 5, SHALL set the ALU opcode width.
REQ-005 Ports (name  direction  width  meaning) SHALL be as follows.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active low.
- A, B  in  DATA_W each  ALU operands.
- opcode  in  OP_W  ALU operation.
- Out  out  DATA_W  ALU result.
- zero  out  1  high when Out == 0.
- flags  out  4  registered {N,Z,C,V}.
- ex_mem_regWrite, mem_wb_regWrite  in  1 each  writeback enables of the later stages.
- ex_mem_registerRD, mem_wb_registerRD  in  RID_W each  destination ids of the later stages.
- id_ex_registerA, id_ex_registerB  in  RID_W each  source ids of the EX-stage instruction.
- forwardA, forwardB  out  2 each  forwarding selects.
- id_ex_memRead  in  1  the EX-stage instruction is a load.
- id_ex_registerRD  in  RID_W  the EX-stage destination id.
- if_id_registerA, if_id_registerB  in  RID_W each  source ids of the ID-stage instruction.
- enablePC  out  1  PC advance permitted.
- muxSelector  out  1  inject a bubble (NOP) into the control signals.

Function
REQ-006 Out and zero SHALL be combinational from A, B and opcode, with zero-cycle latency.
REQ-007 Opcodes SHALL be decoded as follows.
- 0 ADD; 1 SUB (A-B); 2 AND; 3 OR; 4 XOR; 5 NOR; 6 NOT A.
- 7 SLL; 8 SRL; 9 SRA. All shifts shift A by B[4:0].
- 10 SLT signed, 11 SLTU; each gives a result of 1 or 0.
- 12 PASS A (jump-register target); 13 PASS B; 14 LUI, giving B<<16.
- Codes 15-31 SHALL give Out = 0.
REQ-008 Arithmetic SHALL wrap modulo 2^DATA_W.
REQ-009 C SHALL be the carry-out for ADD, SHALL be the borrow (A<B unsigned) for SUB, and SHALL be 0 for all other operations.
REQ-010 V SHALL be the signed overflow for ADD/SUB and SHALL be 0 otherwise.
REQ-011 N SHALL be Out[DATA_W-1], and Z SHALL equal zero.
REQ-012 forwardA SHALL be 2'b10 when ex_mem_regWrite is high and ex_mem_registerRD == id_ex_registerA.
REQ-013 Otherwise, forwardA SHALL be 2'b01 when mem_wb_regWrite is high and mem_wb_registerRD == id_ex_registerA.
REQ-014 Otherwise, forwardA SHALL be 2'b00.
REQ-015 forwardB SHALL follow the same rules as forwardA, using id_ex_registerB.
REQ-016 Forwarding SHALL be combinational, EX/MEM SHALL have priority over MEM/WB, and register 0 SHALL be treated like any other register.
REQ-017 A load-use hazard exists when id_ex_memRead = 1 and id_ex_registerRD equals if_id_registerA or if_id_registerB.
REQ-018 On a load-use hazard, enablePC SHALL be 0 and muxSelector SHALL be 1, combinationally in the same cycle.
REQ-019 Otherwise, enablePC SHALL be 1 and muxSelector SHALL be 0.
REQ-020 forwardA/forwardB SHALL never be 2'b11.

Reset
REQ-021 While reset is low, flags SHALL load 4'b0000 on each rising edge of clock.
REQ-022 While reset is low, forwardA = forwardB = 2'b00, enablePC = 1 and muxSelector = 0, regardless of the other inputs.
REQ-023 Out and zero SHALL remain purely combinational and SHALL NOT be affected by reset.
REQ-024 When reset rises mid-operation, flags SHALL update on the first rising edge at which reset is high.

Configuration
REQ-025 The macro EX_HAZARD_ALU_FLAGS_EN SHALL control the flags register.
REQ-026 With EX_HAZARD_ALU_FLAGS_EN defined, flags SHALL register {N,Z,C,V} of the current operation on every rising edge of clock while reset is high.
REQ-027 Without EX_HAZARD_ALU_FLAGS_EN, flags SHALL be the constant 4'b0000 and no flip-flops SHALL be inferred.
REQ-028 Out, zero, forwarding and hazard behaviour SHALL be identical with and without EX_HAZARD_ALU_FLAGS_EN.

Structure
REQ-029 A shared package SHALL hold the following.
- The opcode enumeration for codes 0-14.
- The forward-select constants FWD_REG = 00, FWD_WB = 01, FWD_MEM = 10.
- The flag bit indices.
REQ-030 A single sub-module, ex_hazard_alu_core (the combinational ALU), SHALL be instantiated; forwarding and hazard logic SHALL be inline in the top level.

Verification
REQ-031 ADD 32'h7FFFFFFF + 1 -> Out = 32'h80000000, zero = 0; flags {N,Z,C,V} = 4'b1001 after the next rising edge (FLAGS_EN defined).
REQ-032 SUB 5 - 5 -> Out = 0, zero = 1; SLT 32'hFFFFFFFF vs 1 -> Out = 1; SLTU 32'hFFFFFFFF vs 1 -> Out = 0; opcode 20 -> Out = 0.
REQ-033 ex_mem_regWrite = 1, ex_mem_registerRD = 3, mem_wb_regWrite = 1, mem_wb_registerRD = 3, id_ex_registerA = 3 -> forwardA = 2'b10; then ex_mem_regWrite = 0 -> forwardA = 2'b01.
REQ-034 id_ex_memRead = 1, id_ex_registerRD = 5, if_id_registerB = 5 -> enablePC = 0, muxSelector = 1; then id_ex_memRead = 0 -> enablePC = 1, muxSelector = 0.
REQ-035 reset held low for 2 cycles with hazard and forwarding match inputs applied -> forwardA = 00, enablePC = 1, flags = 0; after release, the outputs follow REQ-012 to REQ-019.

Source files
------------

// File: rtl/ex_hazard_alu_pkg.sv
// ex_hazard_alu_pkg -- opcodes, forward-select codes and flag bit positions shared by ex_hazard_alu.
`default_nettype none

package ex_hazard_alu_pkg;

   typedef enum logic [4:0] {
      OP_ADD   = 5'd0,
      OP_SUB   = 5'd1,
      OP_AND   = 5'd2,
      OP_OR    = 5'd3,
      OP_XOR   = 5'd4,
      OP_NOR   = 5'd5,
      OP_NOT   = 5'd6,
      OP_SLL   = 5'd7,
      OP_SRL   = 5'd8,
      OP_SRA   = 5'd9,
      OP_SLT   = 5'd10,
      OP_SLTU  = 5'd11,
      OP_PASSA = 5'd12,
      OP_PASSB = 5'd13,
      OP_LUI   = 5'd14
   } alu_op_e;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

`default_nettype wire

// File: rtl/ex_hazard_alu_core.sv
// ex_hazard_alu_core -- purely combinational ALU returning result, carry/borrow and signed overflow.
`default_nettype none

module ex_hazard_alu_core
   import ex_hazard_alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 5
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OP_W-1:0]   opcode,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              overflow
);

   localparam int MSB = DATA_W - 1;

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;
   logic [4:0]      shamt;

   assign sum   = {1'b0, a} + {1'b0, b};
   // Top bit of the widened difference is set exactly when a < b unsigned.
   assign diff  = {1'b0, a} - {1'b0, b};
   assign shamt = b[4:0];

   always_comb begin
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (opcode)
         OP_W'(OP_ADD): begin
            result   = sum[MSB:0];
            carry    = sum[DATA_W];
            overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
         end
         OP_W'(OP_SUB): begin
            result   = diff[MSB:0];
            carry    = diff[DATA_W];
            overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
         end
         OP_W'(OP_AND):   result = a & b;
         OP_W'(OP_OR):    result = a | b;
         OP_W'(OP_XOR):   result = a ^ b;
         OP_W'(OP_NOR):   result = ~(a | b);
         OP_W'(OP_NOT):   result = ~a;
         OP_W'(OP_SLL):   result = a << shamt;
         OP_W'(OP_SRL):   result = a >> shamt;
         OP_W'(OP_SRA):   result = $signed(a) >>> shamt;
         OP_W'(OP_SLT):   result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_W'(OP_SLTU):  result = {{(DATA_W-1){1'b0}}, (a < b)};
         OP_W'(OP_PASSA): result = a;
         OP_W'(OP_PASSB): result = b;
         OP_W'(OP_LUI):   result = b << 16;
         default:         result = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/ex_hazard_alu.sv
// ex_hazard_alu -- EX-stage ALU with forwarding unit, load-use hazard detection and optional
// {N,Z,C,V} flags register enabled by macro EX_HAZARD_ALU_FLAGS_EN.
`default_nettype none

module ex_hazard_alu
   import ex_hazard_alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RID_W  = 4,
   parameter int OP_W   = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [OP_W-1:0]   opcode,
   output logic [DATA_W-1:0] Out,
   output logic              zero,
   output logic [3:0]        flags,
   input  logic              ex_mem_regWrite,
   input  logic              mem_wb_regWrite,
   input  logic [RID_W-1:0]  ex_mem_registerRD,
   input  logic [RID_W-1:0]  mem_wb_registerRD,
   input  logic [RID_W-1:0]  id_ex_registerA,
   input  logic [RID_W-1:0]  id_ex_registerB,
   output logic [1:0]        forwardA,
   output logic [1:0]        forwardB,
   input  logic              id_ex_memRead,
   input  logic [RID_W-1:0]  id_ex_registerRD,
   input  logic [RID_W-1:0]  if_id_registerA,
   input  logic [RID_W-1:0]  if_id_registerB,
   output logic              enablePC,
   output logic              muxSelector
);

   logic       carry;
   logic       overflow;
   logic       load_use;
   logic [3:0] flags_next;

   ex_hazard_alu_core #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
   ) u_core (
      .a        (A),
      .b        (B),
      .opcode   (opcode),
      .result   (Out),
      .carry    (carry),
      .overflow (overflow)
   );

   assign zero = (Out == '0);

   always_comb begin
      flags_next         = 4'b0000;
      flags_next[FLAG_N] = Out[DATA_W-1];
      flags_next[FLAG_Z] = zero;
      flags_next[FLAG_C] = carry;
      flags_next[FLAG_V] = overflow;
   end

   // Reset overrides the control outputs combinationally, not just at the next edge.
   always_comb begin
      forwardA = FWD_REG;
      forwardB = FWD_REG;
      if (reset) begin
         if (ex_mem_regWrite && (ex_mem_registerRD == id_ex_registerA))
            forwardA = FWD_MEM;
         else if (mem_wb_regWrite && (mem_wb_registerRD == id_ex_registerA))
            forwardA = FWD_WB;

         if (ex_mem_regWrite && (ex_mem_registerRD == id_ex_registerB))
            forwardB = FWD_MEM;
         else if (mem_wb_regWrite && (mem_wb_registerRD == id_ex_registerB))
            forwardB = FWD_WB;
      end
   end

   assign load_use = id_ex_memRead &&
                     ((id_ex_registerRD == if_id_registerA) ||
                      (id_ex_registerRD == if_id_registerB));

   assign enablePC    = !(reset && load_use);
   assign muxSelector = reset && load_use;

`ifdef EX_HAZARD_ALU_FLAGS_EN
   logic [3:0] flags_q;

   always_ff @(posedge clock) begin
      if (!reset)
         flags_q <= 4'b0000;
      else
         flags_q <= flags_next;
   end

   assign flags = flags_q;
`else
   logic unused_flags;

   assign unused_flags = ^flags_next;
   assign flags        = 4'b0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_hazard_alu.sv
// tb_ex_hazard_alu -- directed and random scoreboard bench for ex_hazard_alu.
`default_nettype none

module tb_ex_hazard_alu;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] A, B, Out;
   logic [4:0]  opcode;
   logic        zero;
   logic [3:0]  flags;
   logic        ex_mem_regWrite, mem_wb_regWrite;
   logic [3:0]  ex_mem_registerRD, mem_wb_registerRD;
   logic [3:0]  id_ex_registerA, id_ex_registerB;
   logic [1:0]  forwardA, forwardB;
   logic        id_ex_memRead;
   logic [3:0]  id_ex_registerRD, if_id_registerA, if_id_registerB;
   logic        enablePC, muxSelector;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      string       tag;
      logic [31:0] out;
      logic        zero;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        en;
      logic        mux;
      logic [3:0]  flags;
   } exp_t;

   exp_t sb[$];

   always #5 clock = ~clock;

   ex_hazard_alu dut (
      .clock             (clock),
      .reset             (reset),
      .A                 (A),
      .B                 (B),
      .opcode            (opcode),
      .Out               (Out),
      .zero              (zero),
      .flags             (flags),
      .ex_mem_regWrite   (ex_mem_regWrite),
      .mem_wb_regWrite   (mem_wb_regWrite),
      .ex_mem_registerRD (ex_mem_registerRD),
      .mem_wb_registerRD (mem_wb_registerRD),
      .id_ex_registerA   (id_ex_registerA),
      .id_ex_registerB   (id_ex_registerB),
      .forwardA          (forwardA),
      .forwardB          (forwardB),
      .id_ex_memRead     (id_ex_memRead),
      .id_ex_registerRD  (id_ex_registerRD),
      .if_id_registerA   (if_id_registerA),
      .if_id_registerB   (if_id_registerB),
      .enablePC          (enablePC),
      .muxSelector       (muxSelector)
   );

   function automatic logic [1:0] fwd_model(input logic [3:0] src);
      if (!reset) return 2'b00;
      if (ex_mem_regWrite && ex_mem_registerRD == src) return 2'b10;
      if (mem_wb_regWrite && mem_wb_registerRD == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic exp_t model(input string tag);
      exp_t   e;
      longint sa, sb_, sr;
      logic   c, v, hz;
      sa  = longint'($signed(A));
      sb_ = longint'($signed(B));
      c   = 1'b0;
      v   = 1'b0;
      case (opcode)
         5'd0: begin
            e.out = A + B;
            c     = (({1'b0, A} + {1'b0, B}) > 33'h0FFFFFFFF);
            sr    = sa + sb_;
            v     = (sr > 64'sh7FFFFFFF) || (sr < -64'sh80000000);
         end
         5'd1: begin
            e.out = A - B;
            c     = (A < B);
            sr    = sa - sb_;
            v     = (sr > 64'sh7FFFFFFF) || (sr < -64'sh80000000);
         end
         5'd2:  e.out = A & B;
         5'd3:  e.out = A | B;
         5'd4:  e.out = A ^ B;
         5'd5:  e.out = ~(A | B);
         5'd6:  e.out = ~A;
         5'd7:  e.out = A << B[4:0];
         5'd8:  e.out = A >> B[4:0];
         5'd9:  e.out = $signed(A) >>> B[4:0];
         5'd10: e.out = (sa < sb_) ? 32'd1 : 32'd0;
         5'd11: e.out = (A < B) ? 32'd1 : 32'd0;
         5'd12: e.out = A;
         5'd13: e.out = B;
         5'd14: e.out = {B[15:0], 16'h0000};
         default: e.out = 32'd0;
      endcase
      e.tag  = tag;
      e.zero = (e.out == 32'd0);
      e.fa   = fwd_model(id_ex_registerA);
      e.fb   = fwd_model(id_ex_registerB);
      hz     = reset && id_ex_memRead &&
               (id_ex_registerRD == if_id_registerA || id_ex_registerRD == if_id_registerB);
      e.en   = !hz;
      e.mux  = hz;
`ifdef EX_HAZARD_ALU_FLAGS_EN
      e.flags = reset ? {e.out[31], e.zero, c, v} : 4'b0000;
`else
      e.flags = 4'b0000;
`endif
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", name, got, want);
      end
   endtask

   // Push expectation for the current inputs, let one rising edge pass, then pop and compare.
   task automatic step(input string tag);
      exp_t e;
      sb.push_back(model(tag));
      @(posedge clock);
      #1;
      e = sb.pop_front();
      vectors++;
      check({e.tag, ".Out"},         Out,                 e.out);
      check({e.tag, ".zero"},        {31'd0, zero},       {31'd0, e.zero});
      check({e.tag, ".forwardA"},    {30'd0, forwardA},   {30'd0, e.fa});
      check({e.tag, ".forwardB"},    {30'd0, forwardB},   {30'd0, e.fb});
      check({e.tag, ".enablePC"},    {31'd0, enablePC},   {31'd0, e.en});
      check({e.tag, ".muxSelector"}, {31'd0, muxSelector},{31'd0, e.mux});
      check({e.tag, ".flags"},       {28'd0, flags},      {28'd0, e.flags});
   endtask

   task automatic alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                      input string tag);
      A = a; B = b; opcode = op;
      step(tag);
   endtask

   initial begin
      reset = 1'b0;
      A = '0; B = '0; opcode = '0;
      ex_mem_regWrite = 1'b1; ex_mem_registerRD = 4'd3;
      mem_wb_regWrite = 1'b1; mem_wb_registerRD = 4'd3;
      id_ex_registerA = 4'd3; id_ex_registerB = 4'd3;
      id_ex_memRead = 1'b1; id_ex_registerRD = 4'd5;
      if_id_registerA = 4'd0; if_id_registerB = 4'd5;

      // Reset held with every forwarding/hazard match active.
      alu(32'h7FFFFFFF, 32'd1, 5'd0, "rst0");
      alu(32'h7FFFFFFF, 32'd1, 5'd0, "rst1");
      reset = 1'b1;
      alu(32'h7FFFFFFF, 32'd1, 5'd0, "add_ovf_release");
      ex_mem_regWrite = 1'b0;
      step("fwd_wb");
      id_ex_memRead = 1'b0;
      step("no_hazard");
      mem_wb_regWrite = 1'b0;
      step("fwd_none");
      ex_mem_regWrite = 1'b1; ex_mem_registerRD = 4'd0;
      id_ex_registerA = 4'd0; id_ex_registerB = 4'd7;
      mem_wb_regWrite = 1'b1; mem_wb_registerRD = 4'd7;
      step("fwd_r0_mem_b_wb");
      id_ex_memRead = 1'b1; id_ex_registerRD = 4'd0; if_id_registerA = 4'd0;
      step("hazard_a");

      alu(32'd5,        32'd5,        5'd1,  "sub_zero");
      alu(32'd1,        32'd2,        5'd1,  "sub_borrow");
      alu(32'h80000000, 32'd1,        5'd1,  "sub_ovf");
      alu(32'hFFFFFFFF, 32'd1,        5'd0,  "add_carry");
      alu(32'hFFFFFFFF, 32'd1,        5'd10, "slt");
      alu(32'hFFFFFFFF, 32'd1,        5'd11, "sltu");
      alu(32'hDEADBEEF, 32'h12345678, 5'd20, "op20");
      alu(32'hF0F0F0F0, 32'h0FF00FF0, 5'd2,  "and");
      alu(32'hF0F0F0F0, 32'h0FF00FF0, 5'd3,  "or");
      alu(32'hF0F0F0F0, 32'h0FF00FF0, 5'd4,  "xor");
      alu(32'hF0F0F0F0, 32'h0FF00FF0, 5'd5,  "nor");
      alu(32'h0000FFFF, 32'd0,        5'd6,  "not");
      alu(32'h80000001, 32'h00000024, 5'd7,  "sll");
      alu(32'h80000001, 32'h0000001F, 5'd8,  "srl");
      alu(32'h80000000, 32'd4,        5'd9,  "sra");
      alu(32'h00400010, 32'd7,        5'd12, "pass_a");
      alu(32'h00400010, 32'd7,        5'd13, "pass_b");
      alu(32'd0,        32'h0001ABCD, 5'd14, "lui");
      alu(32'd9,        32'd9,        5'd31, "op31");

      for (int i = 0; i < 60; i++) begin
         reset             = ($urandom_range(0, 9) != 0);
         A                 = $urandom;
         B                 = (i % 3 == 0) ? A : $urandom;
         opcode            = 5'($urandom_range(0, 31));
         ex_mem_regWrite   = 1'($urandom);
         mem_wb_regWrite   = 1'($urandom);
         ex_mem_registerRD = 4'($urandom_range(0, 3));
         mem_wb_registerRD = 4'($urandom_range(0, 3));
         id_ex_registerA   = 4'($urandom_range(0, 3));
         id_ex_registerB   = 4'($urandom_range(0, 3));
         id_ex_memRead     = 1'($urandom);
         id_ex_registerRD  = 4'($urandom_range(0, 3));
         if_id_registerA   = 4'($urandom_range(0, 3));
         if_id_registerB   = 4'($urandom_range(0, 3));
         step("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
